// File: rtl/oai21_stream_stage_if.sv
// Handshake and data bundle for oai21_stream_stage.
// The upstream side (in_*) and the downstream side (out_*) share one bundle.
// slave  : the stage itself.
// master : the environment that feeds and drains the stage.
interface oai21_stream_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/oai21_stream_stage.sv
// Registered, handshaked bitwise OAI21 stage: y = ~((a | b) & c).
// One output register plus one skid register.  This sustains one beat per
// clock while in_ready stays registered, so it never depends on out_ready
// within the same cycle.
// Optional statistics counters are enabled by defining OAI_STATS_EN.
// Without that macro, stat_beats and stat_zero are tied to zero.
module oai21_stream_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  oai21_stream_stage_if.slave   bus,
  output logic [CNT_W-1:0]      stat_beats,
  output logic [CNT_W-1:0]      stat_zero
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q,     out_y_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_y_q,    skid_y_d;
  logic             in_ready_q,  in_ready_d;

  logic             in_fire;
  logic [WIDTH-1:0] oai_y;

  // in_ready_q comes out of reset high.  It is masked while rst is asserted,
  // so the stage refuses beats during reset and accepts one on the first
  // cycle after release.
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;

  assign in_fire = bus.in_valid & bus.in_ready;
  assign oai_y   = ~((bus.in_a | bus.in_b) & bus.in_c);

  // Next-state selection for the output and skid registers.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_y_d      = out_y_q;
    skid_valid_d = skid_valid_q;
    skid_y_d     = skid_y_q;
    if (!out_valid_q || bus.out_ready) begin
      // The output slot is free, or it empties at this edge.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_y_d      = skid_y_q;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_y_d = oai_y;
        end
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_y_d = oai_y;
        end
      end
    end else if (in_fire) begin
      // The output is stalled, so the incoming beat parks in the skid register.
      skid_valid_d = 1'b1;
      skid_y_d     = oai_y;
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers, cleared on synchronous reset.  Held beats are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_y_q     <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      skid_valid_q <= skid_valid_d;
      skid_y_q     <= skid_y_d;
      in_ready_q   <= in_ready_d;
    end
  end

`ifdef OAI_STATS_EN
  logic             out_fire;
  logic [CNT_W-1:0] stat_beats_q;
  logic [CNT_W-1:0] stat_zero_q;

  assign out_fire   = out_valid_q & bus.out_ready;
  assign stat_beats = stat_beats_q;
  assign stat_zero  = stat_zero_q;

  // Count output transfers, and those that carry an all-zero result.
  // Both counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats_q <= '0;
      stat_zero_q  <= '0;
    end else if (out_fire) begin
      stat_beats_q <= stat_beats_q + 1'b1;
      if (out_y_q == '0) begin
        stat_zero_q <= stat_zero_q + 1'b1;
      end
    end
  end
`else
  assign stat_beats = '0;
  assign stat_zero  = '0;
`endif

endmodule

// File: doc/oai21_stream_stage.md
Name: oai21_stream_stage

Overview:
Registered, handshaked OAI21 stage for bit-vector streams. Each accepted beat {a, b, c} is evaluated bitwise as y = ~((a | b) & c), giving one result beat.
Sits between an upstream vector producer and a downstream consumer, replacing bare combinational OAI21 gates where a timing boundary and backpressure are needed.
Includes a 2-entry skid buffer so it sustains one beat per clock and keeps in_ready registered.

Parameters:
WIDTH, 8, bit width of the a/b/c operands and of y
CNT_W, 16, width of statistics counters (used only with OAI_STATS_EN)

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_c  input  WIDTH  operand c
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
out_y  output  WIDTH  ~((a | b) & c), bitwise
stat_beats  output  CNT_W  count of accepted output beats (OAI_STATS_EN only)
stat_zero  output  CNT_W  count of output beats with out_y == 0 (OAI_STATS_EN only)

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - rst is sampled on the clk rising edge.
- Handshake definitions:
  - Input transfer when in_valid & in_ready at a rising edge.
  - Output transfer when out_valid & out_ready at a rising edge.
- Reset values:
  - out_valid=0, out_y=0, skid entry empty, stat counters=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
- Datapath:
  - The OAI21 result is computed combinationally from the inputs and captured in the output register.
  - Latency is one cycle: a beat accepted at edge N appears on out_y/out_valid after edge N.
- Storage and in_ready:
  - Main output register plus one skid register.
  - in_ready = ~skid_valid, registered.
- Per-edge cases (no reset):
  - Output register empty, or draining this edge (out_valid & out_ready):
    - If skid is full: skid moves to the output register, and an input transfer (if any) is captured into the skid register.
    - If skid is empty: an input transfer is captured straight into the output register.
    - If there is no source, out_valid goes to 0.
  - Output register stalled (out_valid & ~out_ready) with an input transfer: the beat is captured into the skid register and in_ready drops to 0 for the next cycle.
  - Both registers full: in_ready=0 and no input transfer is possible.
- Ordering and stability:
  - Beats leave in acceptance order; none are dropped or duplicated.
  - out_y and out_valid hold stable while out_valid & ~out_ready.
  - in_valid deasserting without a transfer is legal and has no effect.
- Throughput: one beat/clock sustained when out_ready is held high.
- Reset mid-operation: any held beats (output and skid) are discarded; no output transfer occurs at the reset edge.
- Widths: purely bitwise; no carries. WIDTH=1 is legal.
- Simultaneous input and output transfer with both registers full cannot happen, because in_ready is 0 in that state.

Optional Feature:
Macro OAI_STATS_EN.
- Defined:
  - stat_beats increments on each output transfer.
  - stat_zero increments on each output transfer with out_y == 0.
  - Both wrap modulo 2^CNT_W.
  - Both clear on rst.
- Undefined: stat_beats and stat_zero are tied to 0, and no counter flops are inferred.

Test Plan:
1. Reset check (WIDTH=4): hold rst 3 cycles with in_valid=1 -> out_valid=0, out_y=0, in_ready=0. After release: in_ready=1.
2. Truth check (WIDTH=4, out_ready=1): send a=4'b0011, b=4'b0101, c=4'b1110 -> next cycle out_y=4'b1001, out_valid=1. Then sweep all 8 single-bit combos on bit 0 -> out_y[0] matches ~((a|b)&c).
3. Streaming (out_ready=1): 16 consecutive beats with a=i, b=0, c=4'hF -> out_y=~i in order, one per cycle, with in_ready never low.
4. Backpressure and skid: drop out_ready while 3 beats are offered (a=1,2,3; b=0; c=F) ->
   - out_y holds 4'hE.
   - Beat 2 lands in skid; in_ready=0 next cycle.
   - After out_ready=1: outputs E, D, C in order with no loss.
5. Reset mid-stall: both registers full, assert rst for 1 cycle -> out_valid=0, in_ready=0 during reset, and no stale beat appears afterward.
6. OAI_STATS_EN defined, CNT_W=4:
   - 18 beats with c=0 -> stat_beats=2 (wrapped) and stat_zero=0.
   - Then 3 beats with a=F, c=F -> stat_zero=3.
